// File: rtl/uz_foc_sample_sdiv_pkg.sv
// rtl/uz_foc_sample_sdiv_pkg.sv - shared constants, state type and helpers for the sequential signed divider
// Purpose: widths, iteration count, FSM state encoding, divide-by-zero saturation values.
package uz_foc_sample_sdiv_pkg;

    localparam int DIVISOR_W  = 6;
    localparam int DIVIDEND_W = 25;
    localparam int REM_W      = 7;
    localparam int ITER       = 25;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    // Saturated quotients reported when the divisor is zero.
    localparam logic [DIVIDEND_W-1:0] QMAX = 25'h0FF_FFFF;  // +16777215
    localparam logic [DIVIDEND_W-1:0] QMIN = 25'h100_0000;  // -16777216

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // |v| as unsigned; the most negative value maps onto 0x1000000, which
    // is exactly its magnitude when read as unsigned.
    function automatic logic [DIVIDEND_W-1:0] magnitude(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/uz_foc_sample_sdiv_iter.sv
// rtl/uz_foc_sample_sdiv_iter.sv - one restoring shift/compare/subtract step
// Purpose: combinational single radix-2 step of the divider.
// Ports:
//   partial      in  7  partial remainder before the step
//   bit_in       in  1  next dividend bit (MSB first)
//   divisor      in  6  unsigned divisor
//   partial_next out 7  partial remainder after the step
//   q_bit        out 1  quotient bit produced by this step
module uz_foc_sample_sdiv_iter
    import uz_foc_sample_sdiv_pkg::*;
(
    input  logic [REM_W-1:0]     partial,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     partial_next,
    output logic                 q_bit
);

    logic [REM_W-1:0] shifted;

    always_comb begin
        shifted = {partial[REM_W-2:0], bit_in};
        // A set partial MSB means the true shifted value is >= 128, which is
        // always at least the divisor; the 7-bit difference is still exact
        // modulo 128.
        q_bit        = partial[REM_W-1] || (shifted >= {1'b0, divisor});
        partial_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/uz_foc_sample_sdiv_25s_6ns_27_seq.sv
// rtl/uz_foc_sample_sdiv_25s_6ns_27_seq.sv - sequential 25-bit signed / 6-bit unsigned divider
// Purpose: radix-2 restoring divider with start/done handshake, truncating
//   quotient and remainder carrying the dividend's sign (C semantics).
// Ports:
//   clk, reset (sync, active high), ce (clock enable)
//   start    in  1   request, sampled in IDLE or DONE while ce=1
//   din0     in  6   divisor, unsigned
//   din1     in  25  dividend, signed
//   busy     out 1   operation in progress (CALC/FIX)
//   done     out 1   one-cycle result-valid pulse
//   div_zero out 1   divisor was zero for the current result
//   quot     out 25  signed quotient
//   rem      out 7   signed remainder
module uz_foc_sample_sdiv_25s_6ns_27_seq
    import uz_foc_sample_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 25,
    parameter int dout_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [dout_WIDTH-1:0] quot,
    output logic [REM_W-1:0]      rem
);

    if (ID < 0 || din0_WIDTH != DIVISOR_W || din1_WIDTH != DIVIDEND_W
        || dout_WIDTH != DIVIDEND_W) begin : g_bad_params
        $error("uz_foc_sample_sdiv_25s_6ns_27_seq: only the 6/25/25 configuration is supported");
    end

    state_t                 state;
    logic [CNT_W-1:0]       iter_cnt;
    logic [DIVISOR_W-1:0]   divisor_q;
    // Dividend magnitude shifts out at the MSB while quotient bits shift in
    // at the LSB; after ITER steps it holds the quotient magnitude.
    logic [DIVIDEND_W-1:0]  work;
    logic [REM_W-1:0]       partial;
    // The divisor is never negative, so the quotient sign and the remainder
    // sign are both just the dividend sign.
    logic                   sign;

    logic [REM_W-1:0]       partial_next;
    logic                   q_bit;

    uz_foc_sample_sdiv_iter u_iter (
        .partial      (partial),
        .bit_in       (work[DIVIDEND_W-1]),
        .divisor      (divisor_q),
        .partial_next (partial_next),
        .q_bit        (q_bit)
    );

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            divisor_q <= '0;
            work      <= '0;
            partial   <= '0;
            sign      <= 1'b0;
            div_zero  <= 1'b0;
            quot      <= '0;
            rem       <= '0;
        end else if (ce) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work      <= magnitude(din1);
                        sign      <= din1[DIVIDEND_W-1];
                        divisor_q <= din0;
                        partial   <= '0;
                        iter_cnt  <= '0;
                        state     <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    partial  <= partial_next;
                    work     <= {work[DIVIDEND_W-2:0], q_bit};
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (divisor_q == '0) begin
                        div_zero <= 1'b1;
                        quot     <= sign ? QMIN : QMAX;
                        rem      <= '0;
                    end else begin
                        div_zero <= 1'b0;
                        quot     <= sign ? (~work + 1'b1) : work;
                        rem      <= sign ? (~partial + 1'b1) : partial;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
